// File: rtl/axis_axi_write_burst.sv
// AXI4 write-burst master: takes one AXI-Stream packet and writes it as a single INCR burst.
// WLAST comes from an internal beat counter; s_axis_tlast is only checked for consistency.
module axis_axi_write_burst #(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 64
) (
    input  logic                              m_axi_aclk,
    input  logic                              m_axi_areset,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     m_axi_awaddr,
    output logic [7:0]                        m_axi_awlen,
    output logic [2:0]                        m_axi_awsize,
    output logic [1:0]                        m_axi_awburst,
    output logic [2:0]                        m_axi_awprot,
    output logic                              m_axi_awlock,
    output logic                              m_axi_awvalid,
    input  logic                              m_axi_awready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     m_axi_wdata,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   m_axi_wstrb,
    output logic                              m_axi_wlast,
    output logic                              m_axi_wvalid,
    input  logic                              m_axi_wready,
    input  logic [1:0]                        m_axi_bresp,
    input  logic                              m_axi_bvalid,
    output logic                              m_axi_bready,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     s_axis_tdata,
    input  logic                              s_axis_tvalid,
    output logic                              s_axis_tready,
    input  logic                              s_axis_tlast,
    input  logic                              run,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]     start_addr,
    input  logic [9:0]                        byte_length,
    output logic                              busy,
    output logic                              done,
    output logic [1:0]                        resp,
    output logic                              tlast_err,
    output logic [1:0]                        o_dbg_state
);

    localparam int          LP_BSHIFT = $clog2(C_M_AXI_DATA_WIDTH / 8);
    localparam logic [2:0]  LP_AWSIZE = 3'(LP_BSHIFT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t                          r_state;
    state_t                          w_next;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   r_awaddr;
    logic [7:0]                      r_awlen;
    logic [7:0]                      r_beat_cnt;
    logic                            r_done;
    logic [1:0]                      r_resp;
    logic                            r_tlast_err;

    logic [9:0]                      w_beats;
    logic                            w_start;
    logic                            w_enable;
    logic                            w_wlast;
    logic                            w_beat;

    // Handshakes: a transfer happens on any rising edge where valid && ready;
    // the master holds payload stable while valid is high and ready is low.
    assign w_beats  = byte_length >> LP_BSHIFT;
    assign w_start  = (r_state == S_IDLE) && run && (w_beats != 10'd0);
    assign w_enable = (r_state == S_DATA);
    assign w_wlast  = w_enable && (r_beat_cnt == r_awlen);
    assign w_beat   = w_enable && s_axis_tvalid && m_axi_wready;

    always_ff @(posedge m_axi_aclk) begin
        if (m_axi_areset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_start) w_next = S_ADDR;
            S_ADDR: if (m_axi_awready) w_next = S_DATA;
            S_DATA: if (w_beat && w_wlast) w_next = S_RESP;
            S_RESP: if (m_axi_bvalid) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        m_axi_awvalid = 1'b0;
        m_axi_bready  = 1'b0;
        m_axi_wvalid  = 1'b0;
        s_axis_tready = 1'b0;
        busy          = 1'b0;
        case (r_state)
            S_ADDR: begin
                m_axi_awvalid = 1'b1;
                busy          = 1'b1;
            end
            S_DATA: begin
                m_axi_wvalid  = s_axis_tvalid;
                s_axis_tready = m_axi_wready;
                busy          = 1'b1;
            end
            S_RESP: begin
                m_axi_bready  = 1'b1;
                busy          = 1'b1;
            end
            default: ;
        endcase
    end

    // Counter and status registers; a non-final beat carrying tlast, or a final beat without it, is flagged.
    always_ff @(posedge m_axi_aclk) begin
        if (m_axi_areset) begin
            r_awaddr    <= '0;
            r_awlen     <= 8'd0;
            r_beat_cnt  <= 8'd0;
            r_done      <= 1'b0;
            r_resp      <= 2'b00;
            r_tlast_err <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_start) begin
                r_awaddr    <= start_addr;
                r_awlen     <= w_beats[7:0] - 8'd1;
                r_beat_cnt  <= 8'd0;
                r_tlast_err <= 1'b0;
            end
            if (w_beat) begin
                r_beat_cnt <= r_beat_cnt + 8'd1;
                if (s_axis_tlast != w_wlast) begin
                    r_tlast_err <= 1'b1;
                end
            end
            if ((r_state == S_RESP) && m_axi_bvalid) begin
                r_done <= 1'b1;
                r_resp <= m_axi_bresp;
            end
        end
    end

    assign m_axi_awaddr  = r_awaddr;
    assign m_axi_awlen   = r_awlen;
    assign m_axi_awsize  = LP_AWSIZE;
    assign m_axi_awburst = 2'b01;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awlock  = 1'b0;
    assign m_axi_wdata   = s_axis_tdata;
    assign m_axi_wstrb   = '1;
    assign m_axi_wlast   = w_wlast;
    assign done          = r_done;
    assign resp          = r_resp;
    assign tlast_err     = r_tlast_err;
    assign o_dbg_state   = r_state;

endmodule
